// File: rtl/ysyx_23060111_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060111_pkg
// Brief    : Shared types and defaults for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060111_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } arb_state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060111_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060111_mem_arbiter
// Brief    : IFU/LSU arbiter for the shared data-memory port, one outstanding
//            transaction, with a WAIT-state watchdog that yields an error.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060111_mem_arbiter
    import ysyx_23060111_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_valid,
    output logic              ifu_ready,
    input  logic [AW-1:0]     ifu_addr,
    output logic              ifu_rvalid,
    output logic [DW-1:0]     ifu_rdata,
    output logic              ifu_err,

    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [AW-1:0]     lsu_addr,
    input  logic              lsu_wen,
    input  logic [DW-1:0]     lsu_wdata,
    input  logic [DW/8-1:0]   lsu_wmask,
    output logic              lsu_rvalid,
    output logic [DW-1:0]     lsu_rdata,
    output logic              lsu_err,

    output logic              m_valid,
    input  logic              m_ready,
    output logic [AW-1:0]     m_addr,
    output logic              m_wen,
    output logic [DW-1:0]     m_wdata,
    output logic [DW/8-1:0]   m_wmask,
    input  logic              m_rvalid,
    input  logic [DW-1:0]     m_rdata,

    output logic              timeout_flag
);

    localparam int unsigned   CW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_owner;
    logic [AW-1:0]     r_addr;
    logic              r_wen;
    logic [DW-1:0]     r_wdata;
    logic [DW/8-1:0]   r_wmask;
    logic [DW-1:0]     r_rdata;
    logic              r_err;
    logic              r_drain;
    logic              r_timeout;
    logic [CW-1:0]     r_cnt;

    logic              w_idle;
    logic              w_cnt_last;

    assign w_idle     = (r_state == IDLE);
    assign w_cnt_last = (r_cnt == C_CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (lsu_valid || ifu_valid)  w_state_nxt = REQ;
            REQ:     if (m_ready)                 w_state_nxt = WAIT;
            WAIT:    if (m_rvalid || w_cnt_last)  w_state_nxt = RESP;
            RESP:    w_state_nxt = r_drain ? DRAIN : IDLE;
            DRAIN:   if (m_rvalid)                w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic; response data is gated so it only shows while rvalid is high
    always_comb begin
        ifu_ready    = w_idle & ifu_valid & ~lsu_valid;
        lsu_ready    = w_idle & lsu_valid;
        m_valid      = (r_state == REQ);
        m_addr       = r_addr;
        m_wen        = r_wen;
        m_wdata      = r_wdata;
        m_wmask      = r_wmask;
        ifu_rvalid   = (r_state == RESP) && (r_owner == OWN_IFU);
        lsu_rvalid   = (r_state == RESP) && (r_owner == OWN_LSU);
        ifu_rdata    = ifu_rvalid ? r_rdata : '0;
        ifu_err      = ifu_rvalid & r_err;
        lsu_rdata    = lsu_rvalid ? r_rdata : '0;
        lsu_err      = lsu_rvalid & r_err;
        timeout_flag = r_timeout;
    end

    // Request latches, watchdog and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner   <= OWN_IFU;
            r_addr    <= '0;
            r_wen     <= 1'b0;
            r_wdata   <= '0;
            r_wmask   <= '0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_drain   <= 1'b0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (lsu_valid) begin
                        r_owner <= OWN_LSU;
                        r_addr  <= lsu_addr;
                        r_wen   <= lsu_wen;
                        r_wdata <= lsu_wdata;
                        r_wmask <= lsu_wmask;
                    end else if (ifu_valid) begin
                        r_owner <= OWN_IFU;
                        r_addr  <= ifu_addr;
                        r_wen   <= 1'b0;
                        r_wdata <= '0;
                        r_wmask <= '0;
                    end
                end
                REQ: begin
                    if (m_ready) begin
                        r_cnt <= '0;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (m_rvalid) begin
                        r_rdata <= r_wen ? '0 : m_rdata;
                        r_err   <= 1'b0;
                    end else if (w_cnt_last) begin
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_drain   <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                RESP: begin
                    r_drain <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060111_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060111_mem_arbiter
// Brief    : Directed self-checking bench for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060111_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            ifu_valid, ifu_ready, ifu_rvalid, ifu_err;
    logic [AW-1:0]   ifu_addr;
    logic [DW-1:0]   ifu_rdata;
    logic            lsu_valid, lsu_ready, lsu_wen, lsu_rvalid, lsu_err;
    logic [AW-1:0]   lsu_addr;
    logic [DW-1:0]   lsu_wdata, lsu_rdata;
    logic [DW/8-1:0] lsu_wmask;
    logic            m_valid, m_ready, m_wen, m_rvalid;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata, m_rdata;
    logic [DW/8-1:0] m_wmask;
    logic            timeout_flag;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_23060111_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_valid(ifu_valid), .ifu_ready(ifu_ready), .ifu_addr(ifu_addr),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wen(m_wen),
        .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called in the REQ cycle: immediate m_ready, m_rvalid one cycle later.
    // Returns in the RESP cycle.
    task automatic serve(input logic [DW-1:0] data);
        m_ready = 1'b1;
        step();
        m_ready  = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = data;
        step();
        m_rvalid = 1'b0;
        m_rdata  = '0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ifu_valid = 0; ifu_addr = '0;
        lsu_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        m_ready = 0; m_rvalid = 0; m_rdata = '0;
        step(); step();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_timeout_flag", timeout_flag, 0);
        chk("rst_rvalids", {ifu_rvalid, lsu_rvalid}, 0);
        rst = 1'b0;
        step();

        // IFU read, minimum latency
        ifu_valid = 1; ifu_addr = 32'h8000_0000;
        #1;
        chk("t1_ifu_ready", ifu_ready, 1);
        step();
        ifu_valid = 0;
        chk("t1_m_valid", m_valid, 1);
        chk("t1_m_addr", m_addr, 32'h8000_0000);
        chk("t1_m_wen_mask", {m_wen, m_wmask}, 0);
        serve(32'h0000_0413);
        chk("t1_ifu_rvalid", ifu_rvalid, 1);
        chk("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
        chk("t1_ifu_err", ifu_err, 0);
        chk("t1_lsu_rvalid", lsu_rvalid, 0);
        step();
        chk("t1_rvalid_one_cycle", ifu_rvalid, 0);

        // Simultaneous requests: LSU write wins
        ifu_valid = 1; ifu_addr = 32'h8000_0004;
        lsu_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        #1;
        chk("t2_lsu_ready", lsu_ready, 1);
        chk("t2_ifu_ready_blocked", ifu_ready, 0);
        step();
        lsu_valid = 0; lsu_wen = 0;
        chk("t2_m_addr", m_addr, 32'h8000_0100);
        chk("t2_m_wen", m_wen, 1);
        chk("t2_m_wmask", m_wmask, 4'hF);
        chk("t2_m_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("t2_ifu_ready_req", ifu_ready, 0);
        serve(32'h1234_5678);
        chk("t2_lsu_rvalid", lsu_rvalid, 1);
        chk("t2_lsu_rdata_write", lsu_rdata, 0);
        chk("t2_ifu_rvalid", ifu_rvalid, 0);
        step();
        chk("t2_ifu_granted", ifu_ready, 1);
        step();
        ifu_valid = 0;
        chk("t2_ifu_m_addr", m_addr, 32'h8000_0004);
        chk("t2_ifu_m_wen", m_wen, 0);
        serve(32'h0000_0013);
        chk("t2_ifu_rdata", ifu_rdata, 32'h0000_0013);
        step();

        // m_ready stalled 5 cycles in REQ
        lsu_valid = 1; lsu_addr = 32'h8000_0300; lsu_wen = 1;
        lsu_wdata = 32'hA5A5_5A5A; lsu_wmask = 4'h3;
        step();
        lsu_valid = 0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_fields", {m_valid, m_addr, m_wdata}, {1'b1, 32'h8000_0300, 32'hA5A5_5A5A});
            step();
        end
        chk("t3_m_wmask", m_wmask, 4'h3);
        serve(32'h0);
        chk("t3_m_valid_gone", m_valid, 0);
        chk("t3_lsu_rvalid", lsu_rvalid, 1);
        step();
        chk("t3_single_resp", lsu_rvalid, 0);

        // m_rvalid on the exact timeout cycle
        lsu_valid = 1; lsu_addr = 32'h8000_0500;
        step();
        lsu_valid = 0;
        m_ready = 1;
        step();
        m_ready = 0;
        step(); step(); step();
        m_rvalid = 1; m_rdata = 32'hCAFE_F00D;
        step();
        m_rvalid = 0;
        chk("t5_lsu_rvalid", lsu_rvalid, 1);
        chk("t5_lsu_rdata", lsu_rdata, 32'hCAFE_F00D);
        chk("t5_lsu_err", lsu_err, 0);
        chk("t5_timeout_flag", timeout_flag, 0);
        step();
        lsu_valid = 1; lsu_addr = 32'h8000_0400;
        #1;
        chk("t5_back_idle", lsu_ready, 1);

        // Watchdog expiry, then drained late response
        step();
        lsu_valid = 0;
        m_ready = 1;
        step();
        m_ready = 0;
        step(); step(); step();
        chk("t4_waiting", lsu_rvalid, 0);
        step();
        chk("t4_lsu_rvalid", lsu_rvalid, 1);
        chk("t4_lsu_err", lsu_err, 1);
        chk("t4_lsu_rdata", lsu_rdata, 0);
        chk("t4_timeout_flag", timeout_flag, 1);
        step();
        ifu_valid = 1; ifu_addr = 32'h8000_0008;
        #1;
        chk("t4_drain_no_accept", ifu_ready, 0);
        step();
        m_rvalid = 1; m_rdata = 32'h5555_5555;
        #1;
        chk("t4_drain_no_accept2", ifu_ready, 0);
        step();
        m_rvalid = 0;
        chk("t4_discarded", {ifu_rvalid, lsu_rvalid}, 0);
        chk("t4_idle_accept", ifu_ready, 1);
        chk("t4_flag_sticky", timeout_flag, 1);

        // Asynchronous reset during WAIT
        step();
        ifu_valid = 0;
        m_ready = 1;
        step();
        m_ready = 0;
        chk("t6_in_wait", m_valid, 0);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_outputs", {m_valid, m_addr, ifu_rvalid, lsu_rvalid, timeout_flag}, 0);
        rst = 1'b0;
        ifu_valid = 1; ifu_addr = 32'h8000_000C;
        #1;
        chk("t6_ifu_ready", ifu_ready, 1);
        step();
        ifu_valid = 0;
        chk("t6_m_addr", m_addr, 32'h8000_000C);
        serve(32'h0000_0067);
        chk("t6_ifu_rdata", ifu_rdata, 32'h0000_0067);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_23060111_mem_arbiter.md
# ysyx_23060111_mem_arbiter

Two-master arbiter and transaction sequencer sharing the single data-memory port between instruction fetch (IFU, read-only) and load/store (LSU, read/write). It sits between those units and the memory model and serialises accesses with a valid/ready request handshake and a one-cycle response pulse. One transaction is outstanding at a time. A wait-cycle watchdog converts a hung memory access into an error response.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width; byte-mask width is `DW/8`
- `TIMEOUT`, 255, maximum WAIT cycles before an error response (≥2)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; asynchronous, active-high
- `ifu_valid`/`ifu_ready`  in/out  1  IFU read request handshake
- `ifu_addr`  in  AW  IFU fetch address
- `ifu_rvalid`  out  1  IFU response pulse
- `ifu_rdata`  out  DW  IFU response data
- `ifu_err`  out  1  IFU response is an error
- `lsu_valid`/`lsu_ready`  in/out  1  LSU request handshake
- `lsu_addr`  in  AW  LSU address
- `lsu_wen`  in  1  LSU request is a write
- `lsu_wdata`  in  DW  LSU write data
- `lsu_wmask`  in  DW/8  LSU byte enables
- `lsu_rvalid`/`lsu_rdata`/`lsu_err`  out  1/DW/1  LSU response
- `m_valid`/`m_ready`  out/in  1  memory request handshake
- `m_addr`/`m_wen`/`m_wdata`/`m_wmask`  out  AW/1/DW/DW/8  memory request fields
- `m_rvalid`  in  1  memory response; it also acknowledges writes
- `m_rdata`  in  DW  memory read data
- `timeout_flag`  out  1  sticky; set on the first watchdog expiry

## Operation
- FSM states: IDLE, REQ, WAIT, RESP, DRAIN.
- IDLE:
  - `lsu_ready = lsu_valid`.
  - `ifu_ready = ifu_valid & ~lsu_valid`; LSU has fixed priority.
  - On a handshake, latch the owner and the request fields, then go to REQ.
  - Requests for IFU force wen=0 and wmask=0.
- REQ: `m_valid=1` with the latched fields. Hold the fields stable until `m_ready`, then go to WAIT and clear the watchdog counter.
- WAIT:
  - The counter increments each cycle.
  - On `m_rvalid`: latch `m_rdata` (or 0 for a write), clear the err bit, go to RESP.
  - If the counter reaches `TIMEOUT-1` without `m_rvalid`: latch rdata=0, set the err bit and `timeout_flag`, go to DRAIN-via-RESP. The latched DRAIN bit is consumed when RESP exits.
  - If `m_rvalid` and the timeout coincide, `m_rvalid` wins (normal response).
- RESP:
  - The owner's `*_rvalid=1` for exactly one cycle, with `*_rdata`/`*_err` from the latches. The other master's rvalid stays 0.
  - Next state is IDLE, or DRAIN if a timeout occurred.
- DRAIN: discard the next `m_rvalid`, then go to IDLE. No requests are accepted in DRAIN.
- `m_valid` is 0 in every state except REQ. Upstream `*_ready` is 0 in every state except IDLE.
- Reset (any state, mid-transaction included):
  - State becomes IDLE; counter and latches clear.
  - All outputs go to 0, including `timeout_flag`.
  - An in-flight memory access is abandoned; memory shares `rst`.

## Timing
- Accept at cycle N → `m_valid` at N+1.
- If `m_ready` at N+1 and `m_rvalid` at N+2, then `*_rvalid` at N+3 and IDLE at N+4. Minimum 4 cycles per transaction.
- `*_rdata`/`*_err` are registered and valid only while `*_rvalid=1`.
- `ifu_ready`/`lsu_ready` are combinational from `*_valid` and state. A requester holds valid and fields until ready.
- A request arriving while not IDLE waits. An IFU request pending under continuous LSU traffic starves. This is accepted because the LSU issues at most one access per instruction.
- Timeout error response appears at cycle W+TIMEOUT, where W is the WAIT entry cycle.

## Structure
- Shared package `ysyx_23060111_pkg` holds:
  - state encoding `arb_state_t` (IDLE=0, REQ=1, WAIT=2, RESP=3, DRAIN=4)
  - owner encoding (OWN_IFU=0, OWN_LSU=1)
  - default `TIMEOUT`
- Single module. The watchdog is an inline counter of width `$clog2(TIMEOUT+1)`; no sub-module is needed.

## Test plan
- IFU read at 0x8000_0000, `m_ready` immediate, `m_rvalid` next cycle with 0x0000_0413 → `ifu_rvalid` 3 cycles after accept, `ifu_rdata`=0x0000_0413, `ifu_err`=0, `lsu_rvalid` stays 0.
- IFU and LSU valid in the same cycle; LSU write 0x8000_0100, data 0xDEAD_BEEF, mask 0xF → LSU granted first, with `m_wen`=1, `m_wmask`=0xF. IFU is granted in the IDLE after `lsu_rvalid`.
- `m_ready` held low 5 cycles in REQ → `m_addr`/`m_wdata` stable throughout, single `m_valid`→`m_ready` handshake, one response.
- TIMEOUT=4, memory never responds → `lsu_rvalid`=1 with `lsu_err`=1, `lsu_rdata`=0, `timeout_flag`=1. A later `m_rvalid` is discarded, then IDLE.
- `m_rvalid` on the exact timeout cycle → normal response with err=0, `timeout_flag` stays 0.
- `rst` pulsed asynchronously during WAIT → all outputs 0 immediately. The next IFU request is accepted on the first IDLE cycle after release.
